tt_sweep_capture: RTL
=====================

// Module: tt_sweep_capture
// PURPOSE
//   Exhaustive truth-table extractor for one N-input single-output boolean network
//   (for example a majority-gate net with inputs x0..x6 and output out).
//   On start it drives all 2^N input vectors in ascending order into the network,
//   then captures the network output for each vector. It assembles a 2^N-bit truth
//   table for the downstream classification stage.
//   Sits directly upstream/around the function under test: x_o feeds x0..x(N-1),
//   and f_i takes out.
// PARAMETERS
//   N_IN     7        number of network inputs; truth table width is 2^N_IN
//   DUT_LAT  0        cycles from an x_o vector to its valid f_i (0 = combinational net)
//   EXPECT   128'hfeeaeee8eee8e888eee8e888e888a880  golden table, used only with the macro
// PORTS
//   clk       in   1        single clock, rising edge
//   rst_n     in   1        asynchronous, active-low reset
//   start     in   1        single-cycle request; sampled only in IDLE
//   busy      out  1        high in SWEEP and DRAIN
//   x_o       out  N_IN     input vector to the network; x_o[0] drives x0
//   f_i       in   1        network output
//   tt_o      out  2^N_IN   truth table; tt_o[i] = f(x = i)
//   ones_cnt  out  N_IN+1   number of minterms (popcount of tt_o)
//   tt_valid  out  1        result available; held until accepted
//   tt_ready  in   1        consumer accepts when tt_valid & tt_ready
//   match     out  1        only with TT_EXPECT_CHECK_EN: tt_o == EXPECT
// BEHAVIOUR
// - Reset (async assert, sync release):
//   - state=IDLE
//   - x_o, tt_o, ones_cnt, busy, tt_valid, match all 0
//   - idx and the delay pipeline are cleared
// - FSM states: IDLE -> SWEEP -> DRAIN -> DONE -> IDLE.
// - IDLE:
//   - x_o=0
//   - start=1 clears tt_o and ones_cnt, sets idx=0, goes to SWEEP
// - SWEEP:
//   - x_o=idx; idx increments by 1 every cycle with no stalls
//   - When idx = 2^N_IN-1 the next state is DRAIN; idx does not wrap
// - Capture:
//   - Each issued idx enters a DUT_LAT-deep valid/index delay line
//   - When the delayed entry is valid: tt_o[idx_d] <= f_i and ones_cnt += f_i
//   - DUT_LAT=0 samples f_i at the same edge on which x_o=idx is presented
// - DRAIN:
//   - x_o holds its last value
//   - Lasts DUT_LAT cycles (0 cycles means a direct move to DONE), until the delay line is empty
// - DONE:
//   - tt_valid=1; tt_o and ones_cnt are stable
//   - On tt_valid & tt_ready, the next cycle is IDLE with tt_valid=0
//   - tt_o and ones_cnt keep their value until the next start
// - Latency:
//   - Reference point: the start edge is edge 0
//   - The last capture happens at edge 2^N_IN+DUT_LAT
//   - tt_valid is high in the cycle after that edge
//   - Hence with N_IN=7, DUT_LAT=0, tt_valid rises 129 cycles after start
// - Boundaries:
//   - start outside IDLE is ignored, including in DONE before the handshake
//   - start together with a handshake in DONE is ignored
//   - tt_ready while tt_valid=0 has no effect
//   - ones_cnt reaches 2^N_IN with no overflow (width N_IN+1)
//   - Reset mid-sweep aborts immediately and all outputs return to their reset values
// CONFIGURATION
//   TT_EXPECT_CHECK_EN defined:
//   - Adds the match port, registered in the DONE entry cycle as (tt_o == EXPECT)
//   - match is valid while tt_valid is high and is cleared on start
//   TT_EXPECT_CHECK_EN undefined:
//   - No match port, no EXPECT comparator
//   - EXPECT is ignored; all other behaviour is identical
// TESTING
//   1. f_i driven by the majority net (N_IN=7, DUT_LAT=0), start
//      -> tt_valid after 129 cycles, tt_o=128'hfeeaeee8eee8e888eee8e888e888a880,
//         ones_cnt=64, match=1 (with macro)
//   2. f_i=x_o[0] -> tt_o=128'haaaa...aaaa, ones_cnt=64, match=0 (with macro)
//   3. f_i=1 -> tt_o all ones, ones_cnt=128 (8'h80);
//      f_i=0 -> tt_o=0, ones_cnt=0
//   4. DUT_LAT=2 with a 2-stage registered majority model -> same tt_o as test 1,
//      tt_valid rises 131 cycles after start
//   5. tt_ready low for 10 cycles in DONE; start pulsed during SWEEP and during DONE
//      -> tt_valid and tt_o hold, both starts are ignored, return to IDLE one cycle after tt_ready=1
//   6. rst_n low when idx=40 -> x_o=0, tt_o=0, busy=0, tt_valid=0 immediately;
//      a new start then gives a correct full sweep

Source files
------------

// File: rtl/tt_sweep_capture.sv
// Truth-table extractor: sweeps all 2^N_IN input vectors through a network and captures its output.
// Optional golden-table comparison (match port) is enabled with `define TT_EXPECT_CHECK_EN.
module tt_sweep_capture #(
    parameter int unsigned N_IN    = 7,
    parameter int unsigned DUT_LAT = 0,
    parameter logic [(1 << N_IN)-1:0] EXPECT = 128'hfeeaeee8eee8e888eee8e888e888a880
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   busy,
    output logic [N_IN-1:0]        x_o,
    input  logic                   f_i,
    output logic [(1 << N_IN)-1:0] tt_o,
    output logic [N_IN:0]          ones_cnt,
    output logic                   tt_valid,
`ifdef TT_EXPECT_CHECK_EN
    output logic                   match,
`endif
    input  logic                   tt_ready
);

    localparam int unsigned TT_W = 1 << N_IN;
    localparam logic [N_IN-1:0] IDX_MAX = '1;

    typedef enum logic [1:0] {StIdle, StSweep, StDrain, StDone} state_t;

    state_t              state_q, state_d;
    logic [N_IN-1:0]     idx_q, idx_d;
    logic [TT_W-1:0]     tt_q, tt_d;
    logic [N_IN:0]       ones_q, ones_d;
    logic                start_accept;
    logic                issue;
    logic                cap_v;
    logic [N_IN-1:0]     cap_idx;
    logic                more_inflight;

    if ($bits(EXPECT) != TT_W) begin : g_bad_expect
        $error("EXPECT must be 2**N_IN bits wide");
    end

    assign start_accept = (state_q == StIdle) && start;
    assign issue        = (state_q == StSweep);

    // Valid/index delay line aligning each issued vector with its network response.
    if (DUT_LAT == 0) begin : g_comb
        assign cap_v         = issue;
        assign cap_idx       = idx_q;
        assign more_inflight = 1'b0;
    end else begin : g_pipe
        logic [DUT_LAT-1:0] pipe_v;
        logic [N_IN-1:0]    pipe_idx [DUT_LAT];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pipe_v <= '0;
                for (int i = 0; i < int'(DUT_LAT); i++) pipe_idx[i] <= '0;
            end else begin
                pipe_v[0]   <= issue;
                pipe_idx[0] <= idx_q;
                for (int i = 1; i < int'(DUT_LAT); i++) begin
                    pipe_v[i]   <= pipe_v[i-1];
                    pipe_idx[i] <= pipe_idx[i-1];
                end
            end
        end

        assign cap_v   = pipe_v[DUT_LAT-1];
        assign cap_idx = pipe_idx[DUT_LAT-1];

        // Anything still in flight behind the stage being captured this cycle.
        always_comb begin
            more_inflight = 1'b0;
            for (int i = 0; i < int'(DUT_LAT) - 1; i++) more_inflight = more_inflight | pipe_v[i];
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StSweep;
                    idx_d   = '0;
                end
            end
            StSweep: begin
                if (idx_q == IDX_MAX) begin
                    state_d = (DUT_LAT == 0) ? StDone : StDrain;
                end else begin
                    idx_d = idx_q + N_IN'(1);
                end
            end
            StDrain: begin
                if (!more_inflight) state_d = StDone;
            end
            StDone: begin
                if (tt_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        tt_d   = tt_q;
        ones_d = ones_q;
        if (start_accept) begin
            tt_d   = '0;
            ones_d = '0;
        end else if (cap_v) begin
            tt_d[cap_idx] = f_i;
            ones_d        = ones_q + (N_IN+1)'(f_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            tt_q    <= '0;
            ones_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tt_q    <= tt_d;
            ones_q  <= ones_d;
        end
    end

`ifdef TT_EXPECT_CHECK_EN
    logic match_q;

    // Compare against the next-state table so the final capture is included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_q <= 1'b0;
        end else if (start_accept) begin
            match_q <= 1'b0;
        end else if (state_q != StDone && state_d == StDone) begin
            match_q <= (tt_d == EXPECT);
        end
    end

    assign match = match_q;
`endif

    assign x_o      = (state_q == StIdle) ? '0 : idx_q;
    assign busy     = (state_q == StSweep) || (state_q == StDrain);
    assign tt_valid = (state_q == StDone);
    assign tt_o     = tt_q;
    assign ones_cnt = ones_q;

endmodule
